// File: rtl/hline_pkg.sv
// Shared definitions for the horizontal-line z-buffer command path: sequencer
// states, command width and the bit offset of each 32-bit field in a command.
package hline_pkg;

  localparam int CMD_W = 256;
  localparam int FLD_W = 32;

  localparam int FB_ADDR_OFF    = 0;
  localparam int ZBUFF_ADDR_OFF = 32;
  localparam int DX_OFF         = 64;
  localparam int SLOPE_OFF      = 96;
  localparam int Z1_OFF         = 128;
  localparam int REM_OFF        = 160;
  localparam int ERR_OFF        = 192;
  localparam int RGBX_OFF       = 224;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    ARM    = 3'd2,
    WAIT   = 3'd3,
    RETIRE = 3'd4
  } sched_state_t;

  function automatic logic [FLD_W-1:0] cmd_field(input logic [CMD_W-1:0] cmd,
                                                 input int off);
    return cmd[off +: FLD_W];
  endfunction

endpackage

// File: rtl/hline_cmd_sched_if.sv
// Command push port and engine operand/control buses of hline_cmd_sched.
// slave = scheduler side, master = software/engine side.
interface hline_cmd_sched_if;
  import hline_pkg::*;

  // A command is accepted on every clock edge where cmd_valid && cmd_ready;
  // cmd_ready depends only on FIFO fullness, never on cmd_valid.
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CMD_W-1:0] cmd_data;

  logic [31:0] eng_fb_addr;
  logic [31:0] eng_zbuff_addr;
  logic [31:0] eng_dx;
  logic [31:0] eng_slope;
  logic [31:0] eng_z1;
  logic [31:0] eng_rem;
  logic [31:0] eng_err;
  logic [31:0] eng_rgbx;
  logic        eng_start;
  logic        eng_done;

  modport slave (
    input  cmd_valid, cmd_data, eng_done,
    output cmd_ready, eng_fb_addr, eng_zbuff_addr, eng_dx, eng_slope,
           eng_z1, eng_rem, eng_err, eng_rgbx, eng_start
  );

  modport master (
    output cmd_valid, cmd_data, eng_done,
    input  cmd_ready, eng_fb_addr, eng_zbuff_addr, eng_dx, eng_slope,
           eng_z1, eng_rem, eng_err, eng_rgbx, eng_start
  );

endinterface

// File: rtl/hline_cmd_fifo.sv
// Generic DEPTH x W first-word-fall-through FIFO with synchronous flush.
// Flush wins over push and pop issued in the same cycle.
module hline_cmd_fifo
  import hline_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = CMD_W,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic [AW:0]  o_level,
  output logic         o_full,
  output logic         o_empty
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_level == FULL_LVL);
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_data  = r_mem[r_rd_ptr];

  assign w_push = i_push && !o_full  && !i_flush;
  assign w_pop  = i_pop  && !o_empty && !i_flush;

  // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/hline_cmd_sched.sv
// Line-command queue and sequencer in front of the hline z-buffer engine.
// Optional engine watchdog enabled by defining HLINE_SCHED_WDOG_EN.
module hline_cmd_sched
  import hline_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
`ifdef HLINE_SCHED_WDOG_EN
  ,
  parameter int WDOG_CYC = 65535
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  hline_cmd_sched_if.slave         bus,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     busy,
  output logic [CNT_W-1:0]         retired,
  output logic                     irq,
  output sched_state_t             dbg_state
`ifdef HLINE_SCHED_WDOG_EN
  ,
  output logic                     wdog_err
`endif
);

  sched_state_t     r_state;
  sched_state_t     w_state_nxt;
  logic [CMD_W-1:0] r_cmd;
  logic [CMD_W-1:0] w_fifo_data;
  logic [CNT_W-1:0] r_retired;
  logic             r_irq;
  logic             w_full;
  logic             w_empty;
  logic             w_avail;
  logic             w_push_ok;
  logic             w_pop;
  logic             w_start;
  logic             w_irq_nxt;
  logic             w_count;
  logic             w_dx_pos;
  logic             w_wdog_hit;
  logic             w_skip_count;

  hline_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (bus.cmd_valid),
    .i_pop   (w_pop),
    .i_flush (flush),
    .i_data  (bus.cmd_data),
    .o_data  (w_fifo_data),
    .o_level (fifo_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // A head entry that is being flushed this cycle is never dispatched.
  assign w_avail   = !w_empty && !flush;
  assign w_push_ok = bus.cmd_valid && !w_full && !flush;
  assign w_dx_pos  = $signed(cmd_field(r_cmd, DX_OFF)) > 32'sd0;

`ifdef HLINE_SCHED_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYC + 1);

  logic [WDOG_W-1:0] r_wdog_cnt;
  logic              r_wdog_skip;
  logic              r_wdog_err;

  // The hit fires on the WDOG_CYC-th WAIT cycle that still has no done.
  assign w_wdog_hit   = (r_state == WAIT) && !bus.eng_done &&
                        (r_wdog_cnt == WDOG_W'(WDOG_CYC - 1));
  assign w_skip_count = r_wdog_skip;
  assign wdog_err     = r_wdog_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wdog_cnt  <= '0;
      r_wdog_skip <= 1'b0;
      r_wdog_err  <= 1'b0;
    end else begin
      r_wdog_cnt  <= (r_state == WAIT) ? r_wdog_cnt + 1'b1 : '0;
      r_wdog_skip <= w_wdog_hit;
      if (w_wdog_hit)  r_wdog_err <= 1'b1;
      else if (flush)  r_wdog_err <= 1'b0;
    end
  end
`else
  assign w_wdog_hit   = 1'b0;
  assign w_skip_count = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_start     = 1'b0;
    w_irq_nxt   = 1'b0;
    w_count     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_avail) begin
          w_pop       = 1'b1;
          w_state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        if (w_dx_pos) begin
          w_start     = 1'b1;
          w_state_nxt = ARM;
        end else begin
          w_state_nxt = RETIRE;
        end
      end
      // eng_done may still be high from the previous line during ARM.
      ARM:  w_state_nxt = WAIT;
      WAIT: begin
        if (bus.eng_done || w_wdog_hit) w_state_nxt = RETIRE;
      end
      RETIRE: begin
        w_count = !w_skip_count;
        if (w_avail) begin
          w_pop       = 1'b1;
          w_state_nxt = LAUNCH;
        end else begin
          w_state_nxt = IDLE;
          w_irq_nxt   = !w_push_ok;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cmd     <= '0;
      r_retired <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_irq   <= w_irq_nxt;
      if (w_pop)   r_cmd     <= w_fifo_data;
      if (w_count) r_retired <= r_retired + 1'b1;
    end
  end

  assign bus.cmd_ready      = !w_full;
  assign bus.eng_start      = w_start;
  assign bus.eng_fb_addr    = cmd_field(r_cmd, FB_ADDR_OFF);
  assign bus.eng_zbuff_addr = cmd_field(r_cmd, ZBUFF_ADDR_OFF);
  assign bus.eng_dx         = cmd_field(r_cmd, DX_OFF);
  assign bus.eng_slope      = cmd_field(r_cmd, SLOPE_OFF);
  assign bus.eng_z1         = cmd_field(r_cmd, Z1_OFF);
  assign bus.eng_rem        = cmd_field(r_cmd, REM_OFF);
  assign bus.eng_err        = cmd_field(r_cmd, ERR_OFF);
  assign bus.eng_rgbx       = cmd_field(r_cmd, RGBX_OFF);

  assign busy      = (r_state != IDLE);
  assign retired   = r_retired;
  assign irq       = r_irq;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_hline_cmd_sched.sv
// Self-checking bench for hline_cmd_sched: single-line vector table, then
// multi-cycle sequences (back-to-back, fill, flush, irq suppression, reset).
module tb_hline_cmd_sched;
  import hline_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic               clk   = 1'b0;
  logic               reset = 1'b1;
  logic               flush = 1'b0;
  logic [3:0]         fifo_level;
  logic               busy;
  logic               irq;
  logic [CNT_W-1:0]   retired;
  sched_state_t       dbg_state;
`ifdef HLINE_SCHED_WDOG_EN
  logic               wdog_err;
`endif

  hline_cmd_sched_if bus_if ();

  hline_cmd_sched #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
`ifdef HLINE_SCHED_WDOG_EN
    ,
    .WDOG_CYC (100)
`endif
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus_if),
    .flush      (flush),
    .fifo_level (fifo_level),
    .busy       (busy),
    .retired    (retired),
    .irq        (irq),
    .dbg_state  (dbg_state)
`ifdef HLINE_SCHED_WDOG_EN
    ,
    .wdog_err   (wdog_err)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at time %0t, required finish earlier", $time);
    $fatal(1);
  end

  // Engine model: done drops one cycle after start, rises eng_lat cycles after start.
  int eng_lat = 10;
  int eng_cnt = 0;
  always @(posedge clk) begin
    if (reset) begin
      eng_cnt          <= 0;
      bus_if.eng_done  <= 1'b0;
    end else if (bus_if.eng_start) begin
      eng_cnt <= eng_lat;
    end else if (eng_cnt > 0) begin
      eng_cnt         <= eng_cnt - 1;
      bus_if.eng_done <= (eng_cnt == 1);
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [CMD_W-1:0] exp_q[$];
  int               start_cyc_q[$];
  int               n_checks  = 0;
  int               n_pass    = 0;
  int               start_cnt = 0;
  int               irq_cnt   = 0;
  int               irq_cyc   = 0;
  int               stab_err  = 0;
  int               exp_retired = 0;
  logic [CMD_W-1:0] launch_ops = '0;
  logic [CMD_W-1:0] exp_cmd;
  logic [CMD_W-1:0] w_eng_bus;

  assign w_eng_bus = {bus_if.eng_rgbx, bus_if.eng_err, bus_if.eng_rem, bus_if.eng_z1,
                      bus_if.eng_slope, bus_if.eng_dx, bus_if.eng_zbuff_addr,
                      bus_if.eng_fb_addr};

  always @(negedge clk) begin
    if (!reset) begin
      if (dbg_state == LAUNCH) launch_ops = w_eng_bus;
      else if ((dbg_state inside {ARM, WAIT, RETIRE}) && (w_eng_bus !== launch_ops)) stab_err++;
      if (bus_if.eng_start) begin
        start_cnt++;
        start_cyc_q.push_back(cyc);
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_start: got start fb_addr=%0h dx=%0h, required no start",
                   bus_if.eng_fb_addr, bus_if.eng_dx);
        end else begin
          exp_cmd = exp_q.pop_front();
          if (w_eng_bus === exp_cmd) n_pass++;
          else $display("FAIL sb_start: got operands %0h, required %0h", w_eng_bus, exp_cmd);
        end
      end
      if (irq) begin
        irq_cnt++;
        irq_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [CMD_W-1:0] make_cmd(input logic [31:0] fb, input logic [31:0] dx);
    return {fb + 32'd7, fb + 32'd6, fb + 32'd5, fb + 32'd4, fb + 32'd3, dx, fb + 32'd1, fb};
  endfunction

  task automatic push(input logic [CMD_W-1:0] c);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_data  = c;
    tick(1);
    bus_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_irqs(input int target, input int budget, input string name);
    int n = 0;
    while (irq_cnt < target && n < budget) begin
      tick(1);
      n++;
    end
    check(name, irq_cnt, target);
  endtask

  task automatic wait_starts(input int target, input int budget, input string name);
    int n = 0;
    while (start_cnt < target && n < budget) begin
      tick(1);
      n++;
    end
    check(name, start_cnt, target);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] fb;
    logic [31:0] dx;
    int          lat;
    int          starts;
    int          irq_lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_data  = '0;

    // dx>0: irq 5+lat cycles after push; dx<=0: LAUNCH, RETIRE, irq at +4
    vecs[0] = '{32'h1000_0000, 32'd300,        50, 1, 55};
    vecs[1] = '{32'h1000_0100, 32'd0,          50, 0, 4};
    vecs[2] = '{32'h1000_0200, 32'hFFFF_FFFB,  50, 0, 4};
    vecs[3] = '{32'h1000_0300, 32'h8000_0000,  50, 0, 4};
    vecs[4] = '{32'h1000_0400, 32'd1,          3,  1, 8};
    vecs[5] = '{32'h1000_0500, 32'h7FFF_FFFF,  1,  1, 6};

    tick(3);
    reset = 1'b0;
    tick(1);

    check("rst_cmd_ready", bus_if.cmd_ready, 1);
    check("rst_busy",      busy, 0);
    check("rst_level",     fifo_level, 0);
    check("rst_retired",   retired, 0);
    check("rst_irq",       irq, 0);
    check("rst_start",     bus_if.eng_start, 0);
    check("rst_ops_zero",  (w_eng_bus == '0), 1);
    check("rst_state",     dbg_state, IDLE);

    for (int i = 0; i < 6; i++) begin
      int s0, i0, p;
      s0 = start_cnt;
      i0 = irq_cnt;
      eng_lat = vecs[i].lat;
      if (vecs[i].starts != 0) exp_q.push_back(make_cmd(vecs[i].fb, vecs[i].dx));
      p = cyc;
      push(make_cmd(vecs[i].fb, vecs[i].dx));
      wait_irqs(i0 + 1, 300, "vec_irq");
      check("vec_irq_lat", irq_cyc - p, vecs[i].irq_lat);
      check("vec_starts", start_cnt - s0, vecs[i].starts);
      if (vecs[i].starts != 0) check("vec_start_lat", start_cyc_q[s0] - p, 2);
      exp_retired++;
      check("vec_retired", retired, exp_retired);
      tick(3);
      check("vec_one_irq", irq_cnt, i0 + 1);
      check("vec_idle", busy, 0);
    end

    // back-to-back with stale done held across each start
    begin
      int s0, i0, p;
      s0 = start_cnt;
      i0 = irq_cnt;
      eng_lat = 20;
      for (int k = 0; k < 3; k++) exp_q.push_back(make_cmd(32'h1100_0000 + 32'(k * 16), 32'd40 + 32'(k)));
      p = cyc;
      for (int k = 0; k < 3; k++) push(make_cmd(32'h1100_0000 + 32'(k * 16), 32'd40 + 32'(k)));
      wait_irqs(i0 + 1, 400, "b2b_irq");
      tick(3);
      check("b2b_one_irq", irq_cnt, i0 + 1);
      check("b2b_starts", start_cnt - s0, 3);
      check("b2b_first_lat", start_cyc_q[s0] - p, 2);
      check("b2b_gap1", start_cyc_q[s0 + 1] - start_cyc_q[s0], 23);
      check("b2b_gap2", start_cyc_q[s0 + 2] - start_cyc_q[s0 + 1], 23);
      exp_retired += 3;
      check("b2b_retired", retired, exp_retired);
    end

    // fill the queue behind a running line, then overflow by one
    begin
      int s0, i0;
      s0 = start_cnt;
      i0 = irq_cnt;
      eng_lat = 30;
      exp_q.push_back(make_cmd(32'h2000_0000, 32'd10));
      push(make_cmd(32'h2000_0000, 32'd10));
      wait_starts(s0 + 1, 20, "fill_first_start");
      for (int k = 1; k <= 8; k++) begin
        exp_q.push_back(make_cmd(32'h2000_0000 + 32'(k * 16), 32'd10 + 32'(k)));
        push(make_cmd(32'h2000_0000 + 32'(k * 16), 32'd10 + 32'(k)));
      end
      check("fill_level", fifo_level, 8);
      check("fill_ready", bus_if.cmd_ready, 0);
      check("fill_busy", busy, 1);
      push(make_cmd(32'hDEAD_0000, 32'd99));
      check("fill_drop_level", fifo_level, 8);
      wait_irqs(i0 + 1, 600, "fill_irq");
      tick(3);
      check("fill_starts", start_cnt - s0, 9);
      check("fill_one_irq", irq_cnt, i0 + 1);
      exp_retired += 9;
      check("fill_retired", retired, exp_retired);
    end

    // flush while the second of four lines runs; a push in the flush cycle is dropped
    begin
      int s0, i0;
      s0 = start_cnt;
      i0 = irq_cnt;
      eng_lat = 40;
      for (int k = 0; k < 2; k++) exp_q.push_back(make_cmd(32'h3000_0000 + 32'(k * 16), 32'd20));
      for (int k = 0; k < 4; k++) push(make_cmd(32'h3000_0000 + 32'(k * 16), 32'd20));
      wait_starts(s0 + 2, 200, "flush_second_start");
      tick(5);
      check("flush_level_before", fifo_level, 2);
      flush = 1'b1;
      bus_if.cmd_valid = 1'b1;
      bus_if.cmd_data  = make_cmd(32'h3000_0F00, 32'd20);
      tick(1);
      flush = 1'b0;
      bus_if.cmd_valid = 1'b0;
      check("flush_level_after", fifo_level, 0);
      check("flush_inflight_busy", busy, 1);
      wait_irqs(i0 + 1, 200, "flush_irq");
      tick(60);
      check("flush_starts", start_cnt - s0, 2);
      check("flush_one_irq", irq_cnt, i0 + 1);
      exp_retired += 2;
      check("flush_retired", retired, exp_retired);
    end

    // push landing in the RETIRE cycle suppresses irq; new command runs from IDLE
    begin
      int s0, i0, p;
      s0 = start_cnt;
      i0 = irq_cnt;
      p = cyc;
      push(make_cmd(32'h4000_0000, 32'd0));
      tick(2);
      push(make_cmd(32'h4000_0100, 32'hFFFF_FFFF));
      wait_irqs(i0 + 1, 50, "supp_irq");
      check("supp_irq_lat", irq_cyc - p, 7);
      tick(3);
      check("supp_one_irq", irq_cnt, i0 + 1);
      check("supp_no_start", start_cnt - s0, 0);
      exp_retired += 2;
      check("supp_retired", retired, exp_retired);
    end

`ifdef HLINE_SCHED_WDOG_EN
    // hung engine: watchdog retires without counting, queue moves on
    begin
      int s0, i0, p;
      s0 = start_cnt;
      i0 = irq_cnt;
      eng_lat = 100000;
      exp_q.push_back(make_cmd(32'h5000_0000, 32'd5));
      exp_q.push_back(make_cmd(32'h5000_0100, 32'd6));
      p = cyc;
      push(make_cmd(32'h5000_0000, 32'd5));
      push(make_cmd(32'h5000_0100, 32'd6));
      wait_starts(s0 + 1, 20, "wdog_first_start");
      eng_lat = 10;
      while (cyc < p + 103) tick(1);
      check("wdog_err_before", wdog_err, 0);
      tick(1);
      check("wdog_err_set", wdog_err, 1);
      tick(1);
      check("wdog_no_count", retired, exp_retired);
      wait_irqs(i0 + 1, 100, "wdog_irq");
      check("wdog_starts", start_cnt - s0, 2);
      exp_retired += 1;
      check("wdog_retired", retired, exp_retired);
      check("wdog_err_sticky", wdog_err, 1);
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
      check("wdog_err_flush", wdog_err, 0);
    end
`endif

    // reset in the middle of a line drops everything queued
    begin
      int s0, i0;
      s0 = start_cnt;
      i0 = irq_cnt;
      eng_lat = 40;
      exp_q.push_back(make_cmd(32'h6000_0000, 32'd8));
      push(make_cmd(32'h6000_0000, 32'd8));
      push(make_cmd(32'h6000_0100, 32'd8));
      wait_starts(s0 + 1, 20, "mid_rst_start");
      tick(3);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      check("mid_rst_level", fifo_level, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_retired", retired, 0);
      check("mid_rst_ops_zero", (w_eng_bus == '0), 1);
      exp_retired = 0;
      tick(60);
      check("mid_rst_no_start", start_cnt - s0, 1);
      check("mid_rst_no_irq", irq_cnt, i0);
      push(make_cmd(32'h6000_0200, 32'd0));
      wait_irqs(i0 + 1, 20, "post_rst_irq");
      exp_retired++;
      check("post_rst_retired", retired, exp_retired);
    end

    check("operand_stability", stab_err, 0);
    check("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hline_cmd_sched.md
Name: hline_cmd_sched

Overview:
- Command queue and sequencer for the horizontal-line z-buffer engine.
- Software pushes complete line commands (fb_addr, zbuff_addr, dx, slope, z1, rem, err, rgbx) into a FIFO.
- The block pops one command at a time, holds the engine's operand buses stable, pulses start, waits for done, then retires the command.
- Sits between the AXI-lite slave register file and the engine core; lets the CPU queue lines without polling per line.

Parameters:
- DEPTH, 8, number of queued commands; power of two, 2..64.
- CNT_W, 16, width of the retired-command counter.
- WDOG_CYC, 65535, engine watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command push request.
- cmd_ready  out  1  high when FIFO not full; push occurs when cmd_valid && cmd_ready.
- cmd_data  in  256  {rgbx, err, rem, z1, slope, dx, zbuff_addr, fb_addr}; fb_addr in bits [31:0].
- flush  in  1  discard all queued commands that have not yet been dispatched.
- eng_fb_addr, eng_zbuff_addr, eng_dx, eng_slope, eng_z1, eng_rem, eng_err, eng_rgbx  out  32 each  operand buses to the engine.
- eng_start  out  1  one-cycle start pulse.
- eng_done  in  1  engine done level; stays high until the next start.
- fifo_level  out  log2(DEPTH)+1  number of queued commands.
- busy  out  1  high whenever state != IDLE.
- retired  out  CNT_W  count of retired commands; wraps modulo 2^CNT_W.
- irq  out  1  one-cycle pulse when the queue drains (see below).

Behaviour:
- Reset: FIFO empty, state IDLE, all eng_* buses 0, eng_start 0, retired 0, irq 0, cmd_ready 1, busy 0.
- FIFO:
  - Synchronous, first-word fall-through.
  - A push while full is ignored (cmd_ready is 0).
  - A push and pop in the same cycle leave fifo_level unchanged.
  - Pointers wrap modulo DEPTH.
- State machine:
  - IDLE: if FIFO not empty, pop the head into the operand registers and go to LAUNCH.
  - LAUNCH: check the latched dx. If signed dx <= 0, skip the engine and go to RETIRE. Otherwise assert eng_start for exactly this cycle and go to ARM.
  - ARM: spends one cycle ignoring eng_done, which may still be high from the previous line's DONE state. Go to WAIT.
  - WAIT: when eng_done = 1, go to RETIRE.
  - RETIRE: increment retired. If the FIFO is not empty, pop the next command directly and go to LAUNCH. If it is empty, pulse irq and go to IDLE.
- Operand stability: eng_* registers change only on a pop and hold from LAUNCH through RETIRE, because the engine samples dx/z1 in INIT and rem/err/slope/dx/rgbx throughout the line.
- Latency: first push into an empty idle queue gives eng_start 2 cycles later (pop cycle, then LAUNCH).
- flush:
  - Clears the FIFO in the same cycle.
  - Pushes in that cycle are dropped.
  - The in-flight command, if any, completes and retires normally.
  - irq fires on that retire because the queue is then empty.
- Simultaneous events:
  - irq is suppressed if a push lands in the RETIRE cycle and the FIFO would otherwise be empty. That new command is then popped from IDLE on the next cycle.
  - A retire and a push in the same cycle are both honoured.
- Reset mid-operation returns to IDLE and empties the queue. The engine shares the reset, so no abort handshake is required.

Optional Feature:
- Macro: HLINE_SCHED_WDOG_EN.
- When defined:
  - A cycle counter runs in WAIT.
  - If it reaches WDOG_CYC without eng_done, the block raises sticky output wdog_err (1 bit, cleared by reset or flush), retires the command without incrementing retired, and continues with the next command.
- When undefined: no counter and no wdog_err port; WAIT waits indefinitely.

Decomposition:
- Shared package hline_pkg holds:
  - the state enum {IDLE, LAUNCH, ARM, WAIT, RETIRE};
  - CMD_W = 256;
  - field offset constants for each 32-bit command field, also used by the register file and the engine wrapper.
- Sub-module hline_cmd_fifo: generic DEPTH x CMD_W first-word-fall-through FIFO with push, pop, flush, level, full and empty. The scheduler instantiates it once.

Test Plan:
- Single command, dx=300, engine model raises done 50 cycles after start -> eng_start pulses 2 cycles after push; eng_dx=300 stable until retire; retired=1; one irq pulse.
- Back-to-back: 3 commands pushed, stale done held high across start -> exactly 3 eng_start pulses, each separated by ≥1 ARM cycle; no early retire; retired=3; one irq after the third.
- dx=0 and dx=-5 commands -> no eng_start; each retired in 2 cycles; retired=2.
- Fill to DEPTH=8 while the engine is busy, then push a 9th -> cmd_ready=0, fifo_level=8, 9th dropped; all 8 execute in order (checked by fb_addr sequence).
- flush while the 2nd of 4 commands runs -> 2nd completes, commands 3–4 never start, retired=2, irq pulses once.
- With HLINE_SCHED_WDOG_EN and WDOG_CYC=100, engine never asserts done -> wdog_err=1 at cycle 100 of WAIT; the queue continues to the next command; retired is not incremented for the hung command.
